// File: rtl/led_meter_pkg.sv
// Shared types, default thresholds and the saturating rectifier for the level meter.
// Pure declarations: no latency, no flow control.
// The most negative sample saturates to full-scale magnitude.
package led_meter_pkg;

    localparam int DEF_DWIDTH        = 15;
    localparam int DEF_MW            = DEF_DWIDTH - 1;
    localparam int DEF_TH0           = 512;
    localparam int DEF_TH1           = 2048;
    localparam int DEF_TH2           = 6144;
    localparam int DEF_TH3           = 12288;
    localparam int DEF_CLIP_TH       = 16000;
    localparam int DEF_DECAY_SAMPLES = 64;
    localparam int DEF_DECAY_SHIFT   = 4;
    localparam int DEF_HOLD_SAMPLES  = 24000;

    typedef logic [DEF_MW-1:0] mag_t;

    function automatic mag_t sat_abs(input logic signed [DEF_DWIDTH-1:0] d);
        logic [DEF_DWIDTH-1:0] m;
        m = d[DEF_DWIDTH-1] ? unsigned'(-d) : unsigned'(d);
        // Only -2^(DWIDTH-1) keeps its sign bit after negation.
        return m[DEF_DWIDTH-1] ? '1 : m[DEF_MW-1:0];
    endfunction

endpackage

// File: rtl/led_level_meter_peak_follower.sv
// Peak envelope: instant attack, stepped decay of max(peak>>DECAY_SHIFT, 1) every DECAY_SAMPLES valid samples.
// Latency: peak reflects a valid sample one edge after it is presented.
// No backpressure: accepts a sample on every clock; clear has priority over valid.
module peak_follower #(
    parameter int MW            = 14,
    parameter int DECAY_SAMPLES = 64,
    parameter int DECAY_SHIFT   = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [MW-1:0] mag,
    input  logic          valid,
    input  logic          clear,
    output logic [MW-1:0] peak
);

    localparam int CW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

    logic [CW-1:0] decay_cnt;
    logic          wrap;
    logic [MW-1:0] step;

    assign wrap = (decay_cnt == CW'(DECAY_SAMPLES - 1));

    // Step never exceeds a non-zero peak, so subtraction cannot underflow.
    always_comb begin
        step = peak >> DECAY_SHIFT;
        if (step == '0) step = MW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            peak      <= '0;
            decay_cnt <= '0;
        end else if (clear) begin
            peak      <= '0;
            decay_cnt <= '0;
        end else if (valid) begin
            decay_cnt <= wrap ? '0 : decay_cnt + CW'(1);
            if (mag > peak) begin
                peak <= mag;
            end else if (wrap && (peak != '0)) begin
                peak <= peak - step;
            end
        end
    end

endmodule

// File: rtl/led_level_meter.sv
// Audio level meter: rectify, peak-follow, thermometer-encode to 4 LEDs plus held clip flag on LED3.
// Latency: mag at the tick edge, peak one edge later, leds_o one edge after that.
// No backpressure: full rate on back-to-back ticks; enable_i low clears all state.
module led_level_meter
    import led_meter_pkg::*;
#(
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int TH0           = DEF_TH0,
    parameter int TH1           = DEF_TH1,
    parameter int TH2           = DEF_TH2,
    parameter int TH3           = DEF_TH3,
    parameter int CLIP_TH       = DEF_CLIP_TH,
    parameter int DECAY_SAMPLES = DEF_DECAY_SAMPLES,
    parameter int DECAY_SHIFT   = DEF_DECAY_SHIFT,
    parameter int HOLD_SAMPLES  = DEF_HOLD_SAMPLES
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sample_tick_i,
    input  logic              enable_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic [3:0]        leds_o,
    output logic [DWIDTH-2:0] peak_o
);

    localparam int MW = DWIDTH - 1;
    localparam int HW = $clog2(HOLD_SAMPLES + 1);

    logic [MW-1:0] mag_r;
    logic          tick_d;
    logic [MW-1:0] peak;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mag_r  <= '0;
            tick_d <= 1'b0;
        end else begin
            tick_d <= sample_tick_i & enable_i;
            if (sample_tick_i && enable_i) begin
                mag_r <= sat_abs(data_i);
            end
        end
    end

    peak_follower #(
        .MW            (MW),
        .DECAY_SAMPLES (DECAY_SAMPLES),
        .DECAY_SHIFT   (DECAY_SHIFT)
    ) u_peak (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .mag     (mag_r),
        .valid   (tick_d),
        .clear   (~enable_i),
        .peak    (peak)
    );

    // Clip hold counts sample ticks, not clocks; a new clip restarts it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt <= '0;
        end else if (!enable_i) begin
            hold_cnt <= '0;
        end else if (tick_d) begin
            if (mag_r >= MW'(CLIP_TH)) begin
                hold_cnt <= HW'(HOLD_SAMPLES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            leds_o <= '0;
        end else if (!enable_i) begin
            leds_o <= '0;
        end else begin
            leds_o <= {(peak >= MW'(TH3)) | (hold_cnt != '0),
                       peak >= MW'(TH2),
                       peak >= MW'(TH1),
                       peak >= MW'(TH0)};
        end
    end

    assign peak_o = peak;

endmodule

// File: tb/tb_led_level_meter.sv
// Scoreboarded bench for led_level_meter: tick-level reference model feeds due-stamped expectation queues.
module tb_led_level_meter;

    localparam int DW    = 15;
    localparam int MW    = 14;
    localparam int DECAY = 64;
    localparam int HOLD  = 24000;
    localparam int CLIP  = 16000;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          sample_tick_i = 1'b0;
    logic          enable_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [3:0]    leds_o;
    logic [MW-1:0] peak_o;

    led_level_meter dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .sample_tick_i (sample_tick_i),
        .enable_i      (enable_i),
        .data_i        (data_i),
        .leds_o        (leds_o),
        .peak_o        (peak_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t pk_q[$];
    exp_t led_q[$];
    exp_t mon_e;

    // Reference state, advanced once per accepted sample.
    int m_peak = 0;
    int m_hold = 0;
    int m_ticks = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_pk(input int due, input int val);
        exp_t e;
        e.due = due;
        e.val = val;
        pk_q.push_back(e);
    endfunction

    function automatic void push_led(input int due, input int val);
        exp_t e;
        e.due = due;
        e.val = val;
        led_q.push_back(e);
    endfunction

    function automatic int model_leds();
        int l;
        l = 0;
        if (m_peak >= 512)                 l = l | 1;
        if (m_peak >= 2048)                l = l | 2;
        if (m_peak >= 6144)                l = l | 4;
        if (m_peak >= 12288 || m_hold > 0) l = l | 8;
        return l;
    endfunction

    function automatic void model_tick(input int d);
        int  mag;
        bit  dec;
        int  drop;
        mag = (d < 0) ? -d : d;
        if (mag > 16383) mag = 16383;
        dec = ((m_ticks % DECAY) == DECAY - 1);
        m_ticks++;
        if (mag > m_peak) begin
            m_peak = mag;
        end else if (dec && m_peak > 0) begin
            drop = m_peak / 16;
            if (drop < 1) drop = 1;
            m_peak = m_peak - drop;
        end
        if (mag >= CLIP) m_hold = HOLD;
        else if (m_hold > 0) m_hold--;
    endfunction

    function automatic void model_clear();
        m_peak = 0;
        m_hold = 0;
        m_ticks = 0;
    endfunction

    // Inputs change at the falling edge; the next rising edge is cycle n+1.
    task automatic step(input bit en, input bit tk, input int d);
        int n;
        int prev;
        @(negedge clk_i);
        n = cyc;
        enable_i = en;
        sample_tick_i = tk;
        data_i = DW'(d);
        if (!en) begin
            model_clear();
            push_pk(n + 1, 0);
            push_led(n + 1, 0);
        end else if (tk) begin
            prev = model_leds();
            model_tick(d);
            push_led(n + 2, prev);
            push_pk(n + 2, m_peak);
            push_led(n + 3, model_leds());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 0);
    endtask

    task automatic disable_for(input int n);
        idle(3);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, int'($urandom_range(0, 32767)) - 16384);
    endtask

    function automatic int rand_data();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return -16384;
        if (sel == 1) return ($urandom_range(0, 1) == 1) ? -int'($urandom_range(15990, 16383))
                                                        : int'($urandom_range(15990, 16383));
        if (sel == 2) return int'($urandom_range(0, 20));
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            while (pk_q.size() != 0 && pk_q[0].due <= cyc) begin
                mon_e = pk_q.pop_front();
                if (mon_e.due < cyc) chk("peak_missed", cyc, mon_e.due);
                else chk("peak_o", int'(peak_o), mon_e.val);
            end
            while (led_q.size() != 0 && led_q[0].due <= cyc) begin
                mon_e = led_q.pop_front();
                if (mon_e.due < cyc) chk("leds_missed", cyc, mon_e.due);
                else chk("leds_o", int'(leds_o), mon_e.val);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("reset_leds", int'(leds_o), 0);
        chk("reset_peak", int'(peak_o), 0);
        rst_n_i = 1'b1;

        // Rectification incl. most negative sample
        step(1'b1, 1'b1, -7000);  idle(3);
        step(1'b1, 1'b1, -16384); idle(3);

        // Decay steps, small-peak floor of 1, no underflow at 0
        disable_for(1); step(1'b1, 1'b1, 12288); zeros(63); idle(3);
        disable_for(1); step(1'b1, 1'b1, 10);    zeros(63); idle(3);
        disable_for(1); step(1'b1, 1'b1, 1);     zeros(127); idle(3);

        // Attack on the wrap tick, then back-to-back ticks
        disable_for(1); step(1'b1, 1'b1, 5000); zeros(62); step(1'b1, 1'b1, 6000); idle(3);
        step(1'b1, 1'b1, 100); step(1'b1, 1'b1, 9000); step(1'b1, 1'b1, 200); idle(3);

        // Disable with clip active, ticks ignored, restart from zero
        step(1'b1, 1'b1, 12000); step(1'b1, 1'b1, 16100);
        disable_for(1); step(1'b1, 1'b1, 3000); idle(3);

        // Clip hold length and retrigger
        disable_for(1); step(1'b1, 1'b1, 16100); zeros(24100); idle(3);
        disable_for(1); step(1'b1, 1'b1, 16100); zeros(9999);
        step(1'b1, 1'b1, 16100); zeros(24100); idle(3);

        // Async reset mid-stream, then exact-latency first tick
        step(1'b1, 1'b1, 7000); idle(3);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_leds", int'(leds_o), 0);
        chk("async_rst_peak", int'(peak_o), 0);
        pk_q.delete();
        led_q.delete();
        model_clear();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step(1'b1, 1'b1, 3000); idle(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) disable_for(int'($urandom_range(1, 3)));
            else step(1'b1, 1'($urandom_range(0, 1)), rand_data());
        end

        idle(5);
        chk("queue_drain", pk_q.size() + led_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
